// File: rtl/modulo_contador_garrafas_bcd.sv
// Bottle counter for the filling line.
// The bottle sensor increments the count and the reject sensor decrements it.
// The count is held as packed BCD. Each digit is also mapped through a 4-bit
// display/transfer code. The block flags empty and full, and pulses batch_done
// when a crate reaches MAX_COUNT by an increment.
module modulo_contador_garrafas_bcd #(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 12,
  parameter int WRAP      = 1,
  parameter int ENC_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  sensor_in,
  input  logic                  reject_in,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [4*DIGITS-1:0]   count_enc,
  output logic                  empty,
  output logic                  full,
  output logic                  batch_done
);

  localparam int W = 4 * DIGITS;

  // Convert a binary constant into packed BCD (elaboration time only).
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] res;
    int           r;
    res = '0;
    r   = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic [1:0]   sens_sync_q, rej_sync_q;
  logic         sens_prev_q, rej_prev_q;
  logic [W-1:0] count_q, count_d;
  logic         batch_q, batch_d;
  logic [W-1:0] bcd_inc, bcd_dec;
  logic         inc_edge, dec_edge;

  // Synchronise both sensor levels and keep the previous synchronised value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_sync_q <= '0;
      rej_sync_q  <= '0;
      sens_prev_q <= 1'b0;
      rej_prev_q  <= 1'b0;
    end else begin
      sens_sync_q <= {sens_sync_q[0], sensor_in};
      rej_sync_q  <= {rej_sync_q[0], reject_in};
      sens_prev_q <= sens_sync_q[1];
      rej_prev_q  <= rej_sync_q[1];
    end
  end

  assign inc_edge = sens_sync_q[1] & ~sens_prev_q;
  assign dec_edge = rej_sync_q[1] & ~rej_prev_q;

  // BCD increment: each 9 rolls to 0 and the carry moves to the next digit.
  always_comb begin
    logic carry;
    bcd_inc = count_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // BCD decrement: each 0 rolls to 9 and the borrow moves to the next digit.
  always_comb begin
    logic borrow;
    bcd_dec = count_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Next count: clear beats enable, and enable beats edges. Opposing edges cancel.
  always_comb begin
    count_d = count_q;
    batch_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (inc_edge && !dec_edge) begin
        if (count_q == MAX_BCD) begin
          if (WRAP != 0) count_d = '0;
        end else begin
          count_d = bcd_inc;
          batch_d = (bcd_inc == MAX_BCD);
        end
      end else if (dec_edge && !inc_edge) begin
        if (count_q == '0) begin
          if (WRAP != 0) count_d = MAX_BCD;
        end else begin
          count_d = bcd_dec;
        end
      end
    end
  end

  // Count and crate-complete pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      batch_q <= 1'b0;
    end else begin
      count_q <= count_d;
      batch_q <= batch_d;
    end
  end

  assign count_bcd  = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == MAX_BCD);
  assign batch_done = batch_q;

  // Per-digit output code, taken straight from the count register.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_enc
      logic [3:0] d;
      assign d = count_q[4*gi +: 4];
      if (ENC_MODE == 1) begin : g_remap
        assign count_enc[4*gi +: 4] = {d[0] & ~d[2], d[1], ~d[0] & d[2], d[3]};
      end else begin : g_pass
        assign count_enc[4*gi +: 4] = d;
      end
    end
  endgenerate

endmodule
